// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port arbiter and its helpers.
// Optional build macro used by the arbiter: REGFILE_ARB_LOCK_EN.
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 32;

    // Widest requester index supported (up to 8 requesters).
    localparam int RSP_ID_W = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int req_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One response beat as seen by a requester.
    typedef struct packed {
        logic                     valid;
        logic [RSP_ID_W-1:0]      id;
        logic                     we;
        logic [RF_DATA_WIDTH-1:0] data;
    } rsp_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: scans valid starting at ptr, wrapping
// mod N, and returns the first hit as a one-hot grant plus its index.
// With no valid bit set, grant is zero and idx is 0.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the priority order ptr, ptr+1, ... and keep the first valid entry.
    always_comb begin
        int            c;
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            cand = IW'(c);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter for the single read/write port of the register file.
// Grants at most one requester per cycle, drives the file's we/addr/wdata
// and returns a registered response one cycle after each accept.
// Build option: define REGFILE_ARB_LOCK_EN to add req_lock, which lets a
// requester hold the port across several accesses (atomic read-modify-write).
//
// Handshake: request i is accepted on a rising edge where req_valid[i] and
// req_ready[i] are both high; fields must stay stable while valid and not
// ready, and a requester may drop valid before acceptance. Responses carry
// no ready: rsp_valid is high for exactly one cycle per accept and must be
// consumed by the requester named in rsp_id.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  DATA_WIDTH = RF_DATA_WIDTH,
    parameter int  ADDR_WIDTH = RF_ADDR_WIDTH,
    localparam int IW         = req_idx_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [N_REQ-1:0]            req_lock,
`endif
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rf_we,
    output logic [ADDR_WIDTH-1:0]       rf_addr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    input  logic [DATA_WIDTH-1:0]       rf_rdata,
    output logic                        rsp_valid,
    output logic [IW-1:0]               rsp_id,
    output logic                        rsp_we,
    output logic [DATA_WIDTH-1:0]       rsp_data
);

    logic [IW-1:0]    rr_ptr;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             gany;
    logic             accept;
    logic [IW-1:0]    next_ptr;

`ifdef REGFILE_ARB_LOCK_EN
    logic             lock_active;
    logic [IW-1:0]    lock_owner;
    logic [N_REQ-1:0] owner_mask;

    // While a lock is held only the owner may compete for the port.
    assign owner_mask = N_REQ'(1) << lock_owner;
    assign eligible   = lock_active ? (req_valid & owner_mask) : req_valid;
`else
    assign eligible = req_valid;
`endif

    rr_priority_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // Nothing is granted and nothing is written while reset is held, so the
    // file cannot be disturbed even though it has no reset of its own.
    assign accept    = gany & rst_n;
    assign req_ready = grant & {N_REQ{rst_n}};
    assign rf_we     = accept & req_we[gidx];
    assign rf_addr   = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign rf_wdata  = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];

    // Next search starts just after the requester that was served.
    assign next_ptr = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // Pointer advance and registered response; reads capture the pre-write
    // file contents, writes echo the data that was written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_we    <= 1'b0;
            rsp_data  <= '0;
        end else if (accept) begin
            rr_ptr    <= next_ptr;
            rsp_valid <= 1'b1;
            rsp_id    <= gidx;
            rsp_we    <= req_we[gidx];
            rsp_data  <= req_we[gidx] ? rf_wdata : rf_rdata;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef REGFILE_ARB_LOCK_EN
    // Lock is taken by an accept with req_lock set and released by the
    // owner's next accept without it; only the owner can be accepted meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (accept) begin
            lock_active <= req_lock[gidx];
            lock_owner  <= gidx;
        end
    end
`endif

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Round-robin arbiter sharing the single read/write port of the 32x32 register file among N_REQ requesters (CPU datapath, debug/switch loader, DMA, etc.).
- Each cycle it grants at most one request. It drives the file's write enable, address and write data.
- For every accepted access it returns a registered response one cycle later.
- Sits between the requesters and the register file, which has an enabled-register write and a combinational read mux.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register index width (32 entries).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data, same packing.
- req_ready  out  N_REQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_WIDTH  register-file index for both read and write.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- rf_rdata  in  DATA_WIDTH  register-file combinational read data for rf_addr.
- rsp_valid  out  1  response valid, one cycle after accept.
- rsp_id  out  clog2(N_REQ)  index of the requester being answered.
- rsp_we  out  1  echo of the accepted request's we.
- rsp_data  out  DATA_WIDTH  read data; for a write, the value written.

Behaviour:
- Reset (rst_n low, asynchronous): rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_we=0, rsp_data=0. req_ready and rf_we are forced to 0 while rst_n is low. No write may reach the file during reset.
- Arbitration (combinational):
  - Priority order is rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - The first valid requester in that order gets req_ready.
  - No valid requests -> req_ready=0, rf_we=0. rf_addr/rf_wdata are then don't-care but driven from requester 0.
- Port drive: rf_addr and rf_wdata come from the granted requester. rf_we = grant & req_we[granted]. The file captures the write on the same rising edge as the accept.
- Pointer update on an accept by requester k: rr_ptr <= (k+1) mod N_REQ. No accept -> rr_ptr holds.
- Starvation bound: a continuously valid requester is granted within N_REQ cycles.
- Response, registered:
  - On an accept: rsp_valid<=1, rsp_id<=k, rsp_we<=req_we[k].
  - rsp_data<=rf_rdata for a read (pre-write contents at rf_addr); rsp_data<=req_wdata[k] for a write.
  - Otherwise rsp_valid<=0. rsp_id/rsp_we/rsp_data hold.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput: 1 access per cycle. No response backpressure; requesters must sink rsp_valid.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new value.
- Request rules: a requester may deassert req_valid at any time before it is accepted; the request is then simply dropped. Fields must be stable while valid and not yet ready.
- Reset asserted mid-operation: a pending response is discarded (rsp_valid->0 immediately). Arbitration restarts at requester 0.

Optional Feature:
- REGFILE_ARB_LOCK_EN defined: adds input req_lock[N_REQ].
  - An accept with req_lock[k]=1 sets lock_owner=k, lock_active=1.
  - While lock_active, only lock_owner can be granted; other requesters wait.
  - lock_active clears on the owner's first accept with req_lock=0. This supports atomic read-modify-write sequences.
  - Reset clears lock_active.
- REGFILE_ARB_LOCK_EN not defined: no req_lock port; pure round-robin.

Decomposition:
- Shared package regfile_pkg holds:
  - RF_DATA_WIDTH=32, RF_ADDR_WIDTH=5, RF_DEPTH=32.
  - The requester-index width function (clog2).
  - A response struct/typedef {valid, id, we, data}.
- One natural sub-module: rr_priority_pick. It is purely combinational: takes the valid vector and pointer, returns the one-hot grant plus the encoded index. It is reused by future bus arbiters.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rf_we=0, rsp_valid=0. Release -> requester 0 is granted first.
- Single write then read: req0 writes addr 7 data 32'hDEADBEEF. Next cycle req0 reads addr 7 -> rsp_data=32'hDEADBEEF, rsp_id=0, rsp_we=0 one cycle after the read accept.
- Round-robin: all 4 requesters continuously valid -> grant sequence 0,1,2,3,0,1 on consecutive cycles, one rsp_valid per cycle with matching rsp_id.
- Wrap-around and idle: rr_ptr=3, only req1 valid -> req1 granted, rr_ptr becomes 2. Then no valid for 3 cycles -> rr_ptr stays 2, rsp_valid=0.
- Mid-operation reset: assert rst_n low on the cycle after an accept -> rsp_valid drops to 0 at once. Register contents from writes accepted before reset are preserved (file not reset).
- LOCK_EN build: req2 reads addr 3 with lock=1 while req0/1 are valid. req2 then writes addr 3 with lock=0 -> req0/1 are not granted until after req2's write is accepted.
